aoi_sweep_checker: RTL and testbench
====================================

AOI_SWEEP_CHECKER -- requirements
Module: aoi_sweep_checker

Interface
REQ-001 Parameter: NPAIRS, default 2, number of AND pairs in the checked AND-OR-INVERT function (1..8).
REQ-002 Parameter: ERRW, default 16, width of the error counter.
REQ-003 Derived: W = 2*NPAIRS+1, the vector width.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  one-cycle request that begins a sweep.
REQ-007 Port: hold  input  1  freezes the sweep while high.
REQ-008 Port: vec  output  W  stimulus vector, driven to the external function under test.
REQ-009 Port: y_dut  input  1  combinational response of the function under test to vec.
REQ-010 Port: busy  output  1  high while the sweep is running.
REQ-011 Port: done  output  1  high once a sweep has completed.
REQ-012 Port: pass  output  1  done with zero errors.
REQ-013 Port: err_cnt  output  ERRW  number of mismatching vectors.

Function
REQ-014 Pair i (i=0..NPAIRS-1) shall be bits vec[W-1-2i] and vec[W-2-2i]; the enable bit e shall be vec[0].
REQ-015 golden = ~e | (NAND of every pair all true), i.e. ~(e & OR_i(pair_i[1] & pair_i[0])).
REQ-016 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE, start=1: go to RUN, vec<=0, err_cnt<=0, done<=0, pass<=0.
REQ-018 RUN, hold=0, each cycle: compare y_dut with golden(vec) at the rising edge; on mismatch err_cnt increments; vec increments by 1.
REQ-019 RUN, hold=1: vec, err_cnt and state frozen; no compare.
REQ-020 After the compare of vec = 2^W-1, go to DONE and set done=1; vec wraps to 0.
REQ-021 pass = 1 in DONE only when err_cnt==0.
REQ-022 A sweep with hold low shall take exactly 2^W RUN cycles; busy=1 exactly in RUN.
REQ-023 err_cnt shall saturate at 2^ERRW-1 with no wrap.
REQ-024 start in RUN shall be ignored; start in DONE shall restart as from IDLE (REQ-017).
REQ-025 DONE shall hold done, pass and err_cnt until the next start or reset.
REQ-026 hold and start in IDLE/DONE: start takes effect and hold has no effect that cycle.

Reset
REQ-027 On reset low, asynchronously: state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, capture registers=0; this applies mid-sweep.
REQ-028 Leaving reset shall not start a sweep; start is required.

Configuration
REQ-029 Macro AOI_SWEEP_FAIL_CAPTURE_EN: when defined, add output fail_vec (W) and fail_valid (1); the first mismatching vec of a sweep is latched and fail_valid is set; both are cleared at start.
REQ-030 Without AOI_SWEEP_FAIL_CAPTURE_EN: fail_vec and fail_valid ports and logic are absent; all other behaviour is identical.

Verification (NPAIRS=2, W=5, ERRW=16 unless stated)
REQ-031 y_dut = correct AOI of vec, one start pulse -> busy for 32 cycles, then done=1, err_cnt=0, pass=1.
REQ-032 y_dut tied 1 -> err_cnt=7, pass=0; with capture enabled, fail_vec=5'b00111 and fail_valid=1.
REQ-033 y_dut tied 0 -> err_cnt=25, pass=0; with capture enabled, fail_vec=5'b00000.
REQ-034 Correct y_dut, hold high for 3 cycles at vec=10 -> vec stays 10 for those cycles, busy lasts 35 cycles, err_cnt=0.
REQ-035 Reset low at vec=17 mid-run -> immediately busy=0, vec=0, err_cnt=0; no sweep runs until start.
REQ-036 ERRW=2, y_dut tied 0 -> err_cnt saturates at 3; a second start in DONE clears it and reruns the 32-cycle sweep.

Source files
------------

// File: rtl/aoi_sweep_checker.sv
// ============================================================================
// Module      : aoi_sweep_checker
// Description : Exhaustively sweeps an AND-OR-INVERT function under test and
//               counts vectors where y_dut disagrees with the golden AOI.
//               Optional first-fail capture: define AOI_SWEEP_FAIL_CAPTURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aoi_sweep_checker #(
  parameter int NPAIRS = 2,
  parameter int ERRW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [2*NPAIRS:0] vec,
  input  logic              y_dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
  output logic [2*NPAIRS:0] fail_vec,
  output logic              fail_valid,
`endif
  output logic [ERRW-1:0]   err_cnt
);

  localparam int W = 2*NPAIRS + 1;
  localparam logic [W-1:0]    C_VEC_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]    C_VEC_MAX = {W{1'b1}};
  localparam logic [ERRW-1:0] C_ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0] C_ERR_MAX = {ERRW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            w_any_pair;
  logic            w_golden;
  logic            w_mismatch;
  logic [ERRW-1:0] w_err_next;

  // Pair i occupies the MSB end downward; bit 0 is the enable.
  always_comb begin
    w_any_pair = 1'b0;
    for (int i = 0; i < NPAIRS; i++) begin
      w_any_pair = w_any_pair | (vec[W-1-2*i] & vec[W-2-2*i]);
    end
    w_golden = ~(vec[0] & w_any_pair);
  end

  assign w_mismatch = (y_dut != w_golden);
  assign w_err_next = (w_mismatch && (err_cnt != C_ERR_MAX)) ? (err_cnt + C_ERR_ONE) : err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
      fail_vec   <= '0;
      fail_valid <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // hold is deliberately ignored outside RUN
          if (start) begin
            r_state    <= ST_RUN;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
            fail_vec   <= '0;
            fail_valid <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (!hold) begin
            err_cnt <= w_err_next;
            vec     <= vec + C_VEC_ONE;
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
            if (w_mismatch && !fail_valid) begin
              fail_vec   <= vec;
              fail_valid <= 1'b1;
            end
`endif
            if (vec == C_VEC_MAX) begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_err_next == '0);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aoi_sweep_checker.sv
// Directed bench for aoi_sweep_checker (NPAIRS=2) plus an ERRW=2 saturation instance.
`default_nettype none

module tb_aoi_sweep_checker;

  logic        clk;
  logic        reset;
  logic        start, hold;
  logic [4:0]  vec;
  logic        y_dut;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic        start2;
  logic [4:0]  vec2;
  logic        busy2, done2, pass2;
  logic [1:0]  err_cnt2;
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
  logic [4:0]  fail_vec, fail_vec2;
  logic        fail_valid, fail_valid2;
`endif

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  aoi_sweep_checker #(.NPAIRS(2), .ERRW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .vec(vec), .y_dut(y_dut),
    .busy(busy), .done(done), .pass(pass),
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
    .fail_vec(fail_vec), .fail_valid(fail_valid),
`endif
    .err_cnt(err_cnt)
  );

  aoi_sweep_checker #(.NPAIRS(2), .ERRW(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .hold(1'b0), .vec(vec2), .y_dut(1'b0),
    .busy(busy2), .done(done2), .pass(pass2),
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
    .fail_vec(fail_vec2), .fail_valid(fail_valid2),
`endif
    .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_aoi(input logic [4:0] v);
    return ~(v[0] & ((v[4] & v[3]) | (v[2] & v[1])));
  endfunction

  // mode 0: correct function, 1: tied high, 2: tied low
  always_comb y_dut = (mode == 0) ? model_aoi(vec) : (mode == 1);

  // Stimulus driver: pulse start, then count busy cycles while optionally holding/poking start.
  task automatic sweep(input logic start_hold, input int hold_at, input int start_at,
                       output int cycles, output int at_hold_cnt);
    int holds;
    holds = 0; cycles = 0; at_hold_cnt = 0;
    @(negedge clk); start = 1'b1; hold = start_hold;
    @(negedge clk); start = 1'b0; hold = 1'b0;
    while (busy && cycles < 200) begin
      cycles++;
      if (int'(vec) == hold_at) at_hold_cnt++;
      if (int'(vec) == hold_at && holds < 3) begin
        hold = 1'b1; holds++;
      end else begin
        hold = 1'b0;
      end
      start = (cycles == start_at);
      @(negedge clk);
    end
    hold = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; hold = 1'b0; start2 = 1'b0;
    #3;
    checks++;
    if ({busy, done, pass, vec, err_cnt} !== 24'd0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b pass=%b vec=%0d err=%0d, required all 0", busy, done, pass, vec, err_cnt);
    end
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec !== 5'd0) begin
      errors++; $display("FAIL no_autostart: busy=%b done=%b vec=%0d, required 0 0 0", busy, done, vec);
    end
  endtask

  task automatic test_correct;
    int cyc, nh;
    mode = 0;
    sweep(1'b0, -1, -1, cyc, nh);
    checks++;
    if (cyc !== 32) begin errors++; $display("FAIL correct_busy_cycles: got %0d, required 32", cyc); end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 16'd0 || vec !== 5'd0) begin
      errors++; $display("FAIL correct_result: done=%b pass=%b err=%0d vec=%0d, required 1 1 0 0", done, pass, err_cnt, vec);
    end
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
    checks++;
    if (fail_valid !== 1'b0) begin errors++; $display("FAIL correct_fail_valid: got %b, required 0", fail_valid); end
`endif
  endtask

  task automatic test_tied_high;
    int cyc, nh;
    mode = 1;
    sweep(1'b0, -1, -1, cyc, nh);
    checks++;
    if (err_cnt !== 16'd7 || pass !== 1'b0 || done !== 1'b1 || cyc !== 32) begin
      errors++; $display("FAIL tied_high: err=%0d pass=%b done=%b cyc=%0d, required 7 0 1 32", err_cnt, pass, done, cyc);
    end
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
    checks++;
    if (fail_vec !== 5'b00111 || fail_valid !== 1'b1) begin
      errors++; $display("FAIL tied_high_capture: vec=%b valid=%b, required 00111 1", fail_vec, fail_valid);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 16'd7 || busy !== 1'b0) begin
      errors++; $display("FAIL done_hold: done=%b pass=%b err=%0d busy=%b, required 1 0 7 0", done, pass, err_cnt, busy);
    end
  endtask

  task automatic test_tied_low;
    int cyc, nh;
    mode = 2;
    sweep(1'b0, -1, -1, cyc, nh);
    checks++;
    if (err_cnt !== 16'd25 || pass !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL tied_low: err=%0d pass=%b done=%b, required 25 0 1", err_cnt, pass, done);
    end
`ifdef AOI_SWEEP_FAIL_CAPTURE_EN
    checks++;
    if (fail_vec !== 5'b00000 || fail_valid !== 1'b1) begin
      errors++; $display("FAIL tied_low_capture: vec=%b valid=%b, required 00000 1", fail_vec, fail_valid);
    end
`endif
  endtask

  task automatic test_hold;
    int cyc, nh;
    mode = 0;
    sweep(1'b0, 10, -1, cyc, nh);
    checks++;
    if (nh !== 4) begin errors++; $display("FAIL hold_vec10_cycles: got %0d, required 4", nh); end
    checks++;
    if (cyc !== 35) begin errors++; $display("FAIL hold_busy_cycles: got %0d, required 35", cyc); end
    checks++;
    if (err_cnt !== 16'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL hold_result: err=%0d pass=%b, required 0 1", err_cnt, pass);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, nh;
    mode = 0;
    // restart from DONE with hold high on the start cycle, and a stray start mid-run
    sweep(1'b1, -1, 10, cyc, nh);
    checks++;
    if (cyc !== 32) begin errors++; $display("FAIL restart_busy_cycles: got %0d, required 32", cyc); end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 16'd0) begin
      errors++; $display("FAIL restart_result: done=%b pass=%b err=%0d, required 1 1 0", done, pass, err_cnt);
    end
  endtask

  task automatic test_reset_midrun;
    int n;
    mode = 1;
    n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (vec !== 5'd17 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (vec !== 5'd17 || err_cnt !== 16'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset: vec=%0d err=%0d busy=%b, required 17 2 1", vec, err_cnt, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || vec !== 5'd0 || err_cnt !== 16'd0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: busy=%b vec=%0d err=%0d done=%b, required 0 0 0 0", busy, vec, err_cnt, done);
    end
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec !== 5'd0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b vec=%0d done=%b, required 0 0 0", busy, vec, done);
    end
  endtask

  task automatic test_saturation;
    for (int run = 0; run < 2; run++) begin
      int cyc;
      cyc = 0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      if (run == 1) begin
        checks++;
        if (err_cnt2 !== 2'd0 || done2 !== 1'b0) begin
          errors++; $display("FAIL sat_restart_clear: err=%0d done=%b, required 0 0", err_cnt2, done2);
        end
      end
      while (busy2 && cyc < 200) begin cyc++; @(negedge clk); end
      checks++;
      if (cyc !== 32 || err_cnt2 !== 2'd3 || pass2 !== 1'b0 || done2 !== 1'b1) begin
        errors++; $display("FAIL sat_run%0d: cyc=%0d err=%0d pass=%b done=%b, required 32 3 0 1", run, cyc, err_cnt2, pass2, done2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_tied_high;
    test_tied_low;
    test_hold;
    test_back_to_back;
    test_reset_midrun;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
